// File: rtl/rhythm_pkg.sv
// rhythm_pkg: judge/sound encodings, display ceilings and FSM states for score_ctrl.
package rhythm_pkg;
  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_MISS    = 2'b01;
  localparam logic [1:0] JUDGE_GOOD    = 2'b10;
  localparam logic [1:0] JUDGE_PERFECT = 2'b11;
  localparam logic [1:0] SND_SILENT    = 2'b00;
  localparam logic [1:0] SND_MISS      = 2'b01;
  localparam logic [1:0] SND_GOOD      = 2'b10;
  localparam logic [1:0] SND_PERFECT   = 2'b11;
  localparam logic [15:0] SCORE_MAX_DEF = 16'd9999;
  localparam logic [7:0]  COMBO_MAX_DEF = 8'd99;
  typedef enum logic {ST_IDLE, ST_APPLY} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [IW-1:0] c;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c = IW'((int'(ptr) + i) % N);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    gnt[idx] = found;
  end
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: arbitrates lane judgments and applies them to saturating score/combo and a timed sound command.
module score_ctrl
  import rhythm_pkg::*;
#(
  parameter int          N_LANES     = 4,
  parameter logic [15:0] PTS_PERFECT = 16'd10,
  parameter logic [15:0] PTS_GOOD    = 16'd5,
  parameter logic [15:0] SCORE_MAX   = SCORE_MAX_DEF,
  parameter logic [7:0]  COMBO_MAX   = COMBO_MAX_DEF,
  parameter int          SOUND_HOLD  = 5000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Clear,
  input  logic [N_LANES-1:0]     i_Judge_Valid,
  input  logic [2*N_LANES-1:0]   i_Judge_Code,
  output logic [N_LANES-1:0]     o_Judge_Ack,
  output logic [15:0]            o_Score,
  output logic [7:0]             o_Combo,
  output logic [7:0]             o_Max_Combo,
  output logic [1:0]             o_Sound_Cmd,
  output logic                   o_Busy
);
  localparam int IW = $clog2(N_LANES);
  localparam int CW = $clog2(SOUND_HOLD) + 1;
  state_t               state_q;
  logic [IW-1:0]        ptr_q, gidx;
  logic [N_LANES-1:0]   ack_q, gnt;
  logic                 found;
  logic [1:0]           code_q, snd_q;
  logic [15:0]          score_q, score_d, pts;
  logic [16:0]          sum;
  logic [7:0]           combo_q, combo_d, max_q, max_d;
  logic [CW-1:0]        cnt_q;
  logic                 ev;
  rr_arbiter #(.N(N_LANES), .IW(IW)) u_arb (
    .req   (i_Judge_Valid),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .idx   (gidx),
    .found (found)
  );
  always_comb begin
    ev      = (state_q == ST_APPLY) && (code_q != JUDGE_NONE);
    pts     = code_q == JUDGE_PERFECT ? PTS_PERFECT : code_q == JUDGE_GOOD ? PTS_GOOD : 16'd0;
    sum     = {1'b0, score_q} + {1'b0, pts};
    score_d = sum > {1'b0, SCORE_MAX} ? SCORE_MAX : sum[15:0];
    combo_d = code_q == JUDGE_MISS ? 8'd0 : combo_q >= COMBO_MAX ? COMBO_MAX : combo_q + 8'd1;
    max_d   = combo_d > max_q ? combo_d : max_q;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      code_q  <= JUDGE_NONE;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      snd_q   <= SND_SILENT;
      cnt_q   <= '0;
    end else if (i_Clear) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      snd_q   <= SND_SILENT;
      cnt_q   <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (found) begin
          state_q <= ST_APPLY;
          ack_q   <= gnt;
          code_q  <= i_Judge_Code[{gidx, 1'b0} +: 2];
          ptr_q   <= gidx == IW'(N_LANES - 1) ? '0 : gidx + 1'b1;
        end
      end else begin
        state_q <= ST_IDLE;
        ack_q   <= '0;
        if (ev) begin
          score_q <= score_d;
          combo_q <= combo_d;
          max_q   <= max_d;
        end
      end
      // A new event retriggers the hold; otherwise count down then go silent.
      if (ev) begin
        snd_q <= code_q;
        cnt_q <= CW'(SOUND_HOLD - 1);
      end else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else snd_q <= SND_SILENT;
    end
  end
  assign o_Judge_Ack = ack_q;
  assign o_Score     = score_q;
  assign o_Combo     = combo_q;
  assign o_Max_Combo = max_q;
  assign o_Sound_Cmd = snd_q;
  assign o_Busy      = state_q == ST_APPLY;
endmodule
